// File: rtl/pc_ram_pkg.sv
// Shared types and helpers for the pc_ram simple-dual-port memory family.
// Defines the sequencer state, the read-during-write modes and a lane-to-bit mask expander.
package pc_ram_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;

   localparam int MAX_DATA_W = 256;
   localparam int MAX_LANES  = 32;

   // Expands one enable bit per lane into a bit mask covering that lane's bits.
   function automatic logic [MAX_DATA_W-1:0] lane_mask(input logic [MAX_LANES-1:0] be,
                                                      input int lane_w);
      logic [MAX_DATA_W-1:0] lane_ones;
      logic [MAX_DATA_W-1:0] m;
      logic [MAX_LANES-1:0]  be_s;
      lane_ones = (MAX_DATA_W'(1) << lane_w) - MAX_DATA_W'(1);
      m         = '0;
      be_s      = be;
      for (int l = 0; l < MAX_LANES; l++) begin
         if (be_s[0]) m = m | (lane_ones << (l * lane_w));
         be_s = be_s >> 1;
      end
      return m;
   endfunction

endpackage

// File: rtl/pc_ram_clear_ctrl.sv
// Clear sequencer: sweeps every address with zeros after reset or on request,
// and owns the ready flag that gates user traffic.
module pc_ram_clear_ctrl
   import pc_ram_pkg::*;
#(
   parameter int ADDR_WIDTH     = 10,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_req,
   output logic                  ready,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
   localparam state_e                RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  ready_q, ready_d;

   // NOTE: state flops use <= so each one samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RESET_STATE;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   // NOTE: every variable gets a default first so no path through the case can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_ADDR) state_d = IDLE;
         end
         default: state_d = RESET_STATE;
      endcase
      // Registered so ready stays low throughout reset even when the reset state is IDLE.
      ready_d = (state_d == IDLE);
   end

   always_comb begin
      ready    = ready_q;
      clr_we   = (state_q == CLEAR);
      clr_addr = cnt_q;
   end

endmodule

// File: rtl/pc_ram_dp.sv
// Simple-dual-port RAM with lane byte enables, selectable read-during-write,
// optional output register and a hardware clear sweep.
module pc_ram_dp
   import pc_ram_pkg::*;
#(
   parameter int    DATA_WIDTH     = 16,
   parameter int    ADDR_WIDTH     = 10,
   parameter int    LANE_WIDTH     = 8,
   parameter int    RDW_MODE       = RDW_READ_FIRST,
   parameter bit    OUT_REG        = 1'b0,
   parameter bit    CLEAR_ON_RESET = 1'b1,
   parameter string INIT_FILE      = "",
   localparam int   NUM_LANES      = DATA_WIDTH / LANE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_req,
   output logic                  ready,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [NUM_LANES-1:0]  wr_be,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  user_wr, rd_fire, wr_we;
   logic [ADDR_WIDTH-1:0] wr_a;
   logic [DATA_WIDTH-1:0] wr_d, be_mask, rd_word;
   logic [NUM_LANES-1:0]  wr_lanes;

   pc_ram_clear_ctrl #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear_ctrl (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_req  (clr_req),
      .ready    (ready),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   always_comb begin
      user_wr  = ready & wr_en;
      rd_fire  = ready & rd_en;
      wr_we    = clr_we | user_wr;
      wr_a     = clr_we ? clr_addr : wr_addr;
      wr_d     = clr_we ? '0 : wr_data;
      wr_lanes = clr_we ? '1 : wr_be;
      be_mask  = DATA_WIDTH'(lane_mask(MAX_LANES'(wr_be), LANE_WIDTH));
      rd_word  = mem[rd_addr];
      // Write-first forwards only the lanes being written; the rest come from the array.
      if (RDW_MODE == RDW_WRITE_FIRST && user_wr && (wr_addr == rd_addr))
         rd_word = (rd_word & ~be_mask) | (wr_data & be_mask);
   end

   // NOTE: the array has no reset; zeroing is the clear sweep's job, which keeps it mappable to RAM.
   always_ff @(posedge clk) begin
      if (wr_we) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_lanes[i]) mem[wr_a][i*LANE_WIDTH +: LANE_WIDTH] <= wr_d[i*LANE_WIDTH +: LANE_WIDTH];
         end
      end
   end

   logic                  s1_valid_q, s1_valid_d;
   logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

   always_comb begin
      s1_valid_d = rd_fire;
      s1_data_d  = rd_fire ? rd_word : s1_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
      end
   end

   generate
      if (OUT_REG) begin : g_out_reg
         logic                  out_valid_q, out_valid_d;
         logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

         always_comb begin
            out_valid_d = s1_valid_q;
            out_data_d  = s1_valid_q ? s1_data_q : out_data_q;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               out_valid_q <= 1'b0;
               out_data_q  <= '0;
            end else begin
               out_valid_q <= out_valid_d;
               out_data_q  <= out_data_d;
            end
         end

         assign rd_valid = out_valid_q;
         assign rd_data  = out_data_q;
      end else begin : g_no_out_reg
         assign rd_valid = s1_valid_q;
         assign rd_data  = s1_data_q;
      end
   endgenerate

endmodule

// File: tb/tb_pc_ram_dp.sv
// Bench for pc_ram_dp: three instances (read-first, write-first, read-first with output
// register) share stimulus; a memory model feeds a per-instance scoreboard of expected reads.
module tb_pc_ram_dp;

   localparam int DW = 16;
   localparam int AW = 4;
   localparam int NI = 3;

   typedef struct {
      int          inst;
      logic [DW-1:0] data;
      int          due;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clr_req;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [1:0]    wr_be;
   logic          rd_en;
   logic [AW-1:0] rd_addr;

   logic [NI-1:0] ready_v;
   logic [NI-1:0] rd_valid_v;
   logic [DW-1:0] rd_data_v [NI];

   exp_t          sb [$];
   logic [DW-1:0] m_mem [2**AW];
   logic          m_ready = 1'b0;
   logic [AW-1:0] m_cnt = '0;
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   pc_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(8), .RDW_MODE(0),
               .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1)) u_rf (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready_v[0]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_v[0]), .rd_valid(rd_valid_v[0]));

   pc_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(8), .RDW_MODE(1),
               .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1)) u_wf (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready_v[1]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_v[1]), .rd_valid(rd_valid_v[1]));

   pc_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(8), .RDW_MODE(0),
               .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b1)) u_or (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready_v[2]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_v[2]), .rd_valid(rd_valid_v[2]));

   task automatic push_exp(input int inst, input logic [DW-1:0] data, input int due);
      exp_t e;
      e.inst = inst;
      e.data = data;
      e.due  = due;
      sb.push_back(e);
   endtask

   task automatic idle_inputs();
      clr_req = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      wr_be   = '0;
      rd_en   = 1'b0;
      rd_addr = '0;
   endtask

   // Advances one clock; the model consumes the inputs that were stable across that edge.
   task automatic tick();
      logic [DW-1:0] old_w, mrg_w;
      @(posedge clk);
      if (m_ready && rd_en) begin
         old_w = m_mem[rd_addr];
         mrg_w = old_w;
         if (wr_en && wr_addr == rd_addr) begin
            if (wr_be[0]) mrg_w[7:0]  = wr_data[7:0];
            if (wr_be[1]) mrg_w[15:8] = wr_data[15:8];
         end
         push_exp(0, old_w, cyc + 1);
         push_exp(1, mrg_w, cyc + 1);
         push_exp(2, old_w, cyc + 2);
      end
      if (m_ready && wr_en) begin
         if (wr_be[0]) m_mem[wr_addr][7:0]  = wr_data[7:0];
         if (wr_be[1]) m_mem[wr_addr][15:8] = wr_data[15:8];
      end
      if (!m_ready) begin
         m_mem[m_cnt] = '0;
         if (m_cnt == AW'(15)) m_ready = 1'b1;
         m_cnt = m_cnt + AW'(1);
      end else if (clr_req) begin
         m_ready = 1'b0;
         m_cnt   = '0;
      end
      cyc++;
      #1;
   endtask

   task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
      idle_inputs();
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      tick();
      idle_inputs();
   endtask

   task automatic read_word(input logic [AW-1:0] a);
      idle_inputs();
      rd_en = 1'b1; rd_addr = a;
      tick();
      idle_inputs();
   endtask

   task automatic drain(input string name);
      idle_inputs();
      repeat (3) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s drain: %0d reads still outstanding, required 0", name, sb.size());
      end
      sb.delete();
   endtask

   task automatic assert_reset(input string name);
      rst_n   = 1'b0;
      m_ready = 1'b0;
      m_cnt   = '0;
      sb.delete();
      #1;
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (ready_v[i] !== 1'b0 || rd_valid_v[i] !== 1'b0 || rd_data_v[i] !== '0) begin
            errors++;
            $display("FAIL %s inst%0d: ready=%b rd_valid=%b rd_data=%h, required 0/0/0000",
                     name, i, ready_v[i], rd_valid_v[i], rd_data_v[i]);
         end
      end
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   task automatic count_ready(input string name);
      int n;
      n = 0;
      while (ready_v !== 3'b111 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL %s sweep length: ready after %0d cycles, required 16", name, n);
      end
   endtask

   // Scoreboard: ready tracks the model every cycle, each rd_valid pops the oldest expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         for (int i = 0; i < NI; i++) begin
            int idx;
            idx = -1;
            for (int k = 0; k < sb.size(); k++) if (idx < 0 && sb[k].inst == i) idx = k;
            checks++;
            if (ready_v[i] !== m_ready) begin
               errors++;
               $display("FAIL ready inst%0d cycle %0d: got %b required %b", i, cyc, ready_v[i], m_ready);
            end
            if (rd_valid_v[i] !== 1'b0) begin
               checks++;
               if (idx < 0) begin
                  errors++;
                  $display("FAIL rd_valid inst%0d cycle %0d: got %b with no read outstanding", i, cyc, rd_valid_v[i]);
               end else begin
                  if (rd_valid_v[i] !== 1'b1 || sb[idx].due != cyc || rd_data_v[i] !== sb[idx].data) begin
                     errors++;
                     $display("FAIL read inst%0d: got %h valid=%b at cycle %0d, required %h at cycle %0d",
                              i, rd_data_v[i], rd_valid_v[i], cyc, sb[idx].data, sb[idx].due);
                  end
                  sb.delete(idx);
               end
            end else if (idx >= 0 && sb[idx].due <= cyc) begin
               checks++;
               errors++;
               $display("FAIL read inst%0d: no rd_valid at cycle %0d, required %h", i, cyc, sb[idx].data);
               sb.delete(idx);
            end
         end
      end
   end

   task automatic test_reset();
      idle_inputs();
      assert_reset("reset");
      count_ready("reset");
   endtask

   task automatic test_clear_readback();
      idle_inputs();
      for (int a = 0; a < 16; a++) begin
         rd_en = 1'b1; rd_addr = AW'(a);
         tick();
      end
      drain("clear_readback");
   endtask

   task automatic test_lane_write();
      write_word(AW'(3), 16'hFFFF, 2'b11);
      write_word(AW'(3), 16'hA5C3, 2'b01);
      read_word(AW'(3));
      write_word(AW'(15), 16'h1357, 2'b10);
      write_word(AW'(15), 16'hFFFF, 2'b00);
      read_word(AW'(15));
      drain("lane_write");
   endtask

   task automatic test_rdw();
      idle_inputs();
      wr_en = 1'b1; wr_addr = AW'(7); wr_data = 16'h1234; wr_be = 2'b11;
      rd_en = 1'b1; rd_addr = AW'(7);
      tick();
      write_word(AW'(8), 16'hAAAA, 2'b11);
      wr_en = 1'b1; wr_addr = AW'(8); wr_data = 16'h5555; wr_be = 2'b01;
      rd_en = 1'b1; rd_addr = AW'(8);
      tick();
      wr_en = 1'b1; wr_addr = AW'(9); wr_data = 16'h9999; wr_be = 2'b11;
      rd_en = 1'b1; rd_addr = AW'(8);
      tick();
      read_word(AW'(7));
      read_word(AW'(9));
      drain("rdw");
   endtask

   task automatic test_back_to_back();
      write_word(AW'(1), 16'h1111, 2'b11);
      write_word(AW'(2), 16'h2222, 2'b11);
      write_word(AW'(3), 16'h3333, 2'b11);
      for (int a = 1; a <= 3; a++) begin
         rd_en = 1'b1; rd_addr = AW'(a);
         tick();
      end
      drain("back_to_back");
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         wr_en   = 1'($urandom_range(0, 1));
         wr_addr = AW'($urandom_range(0, 15));
         wr_data = DW'($urandom);
         wr_be   = 2'($urandom_range(0, 3));
         rd_en   = 1'($urandom_range(0, 1));
         rd_addr = ($urandom_range(0, 1) == 1) ? wr_addr : AW'($urandom_range(0, 15));
         tick();
      end
      drain("random");
   endtask

   task automatic test_clr_req();
      for (int a = 0; a < 16; a++) write_word(AW'(a), DW'($urandom) | 16'h0101, 2'b11);
      clr_req = 1'b1;
      wr_en = 1'b1; wr_addr = AW'(4); wr_data = 16'hC0DE; wr_be = 2'b11;
      rd_en = 1'b1; rd_addr = AW'(5);
      tick();
      idle_inputs();
      begin
         int n;
         n = 0;
         while (ready_v !== 3'b111 && n < 40) begin
            wr_en = 1'b1; wr_addr = AW'(n); wr_data = 16'hDEAD; wr_be = 2'b11;
            rd_en = 1'b1; rd_addr = AW'(n);
            clr_req = 1'b1;
            tick();
            n++;
         end
         checks++;
         if (n != 16) begin
            errors++;
            $display("FAIL clr_req sweep length: ready after %0d cycles, required 16", n);
         end
      end
      idle_inputs();
      for (int a = 0; a < 16; a++) begin
         rd_en = 1'b1; rd_addr = AW'(a);
         tick();
      end
      drain("clr_req");
   endtask

   task automatic test_reset_mid_sweep();
      write_word(AW'(2), 16'hBEEF, 2'b11);
      read_word(AW'(2));
      drain("mid_sweep_pre");
      clr_req = 1'b1;
      tick();
      idle_inputs();
      repeat (5) tick();
      assert_reset("mid_sweep_reset");
      count_ready("mid_sweep");
      for (int a = 0; a < 16; a++) begin
         rd_en = 1'b1; rd_addr = AW'(a);
         tick();
      end
      drain("mid_sweep_post");
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_clear_readback();
      test_lane_write();
      test_rdw();
      test_back_to_back();
      test_random();
      test_clr_req();
      test_reset_mid_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
